// File: rtl/ddc_edid_slave_if.sv
// Byte-memory port between the DDC slave engine and the EDID image store.
// The engine owns the address/write side; the memory returns registered read data.
interface ddc_edid_slave_if;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/ddc_edid_slave.sv
// I2C slave for the HDMI DDC bus answering as the EDID EEPROM (0xA0/0xA1).
// Filters the pad inputs, tracks a byte offset and serves sequential reads and writes.
module ddc_edid_slave #(
  parameter logic [6:0] I2C_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic                    clk50,
  input  logic                    rst_n,
  input  logic                    scl_in,
  input  logic                    sda_in,
  output logic                    sda_oe,
  output logic                    busy,
  ddc_edid_slave_if.master        mem_bus
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, OFFSET, OFFSET_ACK,
    WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } state_t;

  // Index 0 = SCL, index 1 = SDA throughout the conditioning pipeline.
  logic [1:0]    sync1_q, sync2_q, filt_q, filt_d, prev_q;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] offset_q, offset_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       mem_we_q, mem_we_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic [1:0] pref_q, pref_d;

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, byte_done;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CW'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
        else                                 cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign scl_f     = filt_q[0];
  assign sda_f     = filt_q[1];
  assign scl_rise  = scl_f & ~prev_q[0];
  assign scl_fall  = ~scl_f & prev_q[0];
  assign start_det = scl_f & prev_q[0] & prev_q[1] & ~sda_f;
  assign stop_det  = scl_f & prev_q[0] & ~prev_q[1] & sda_f;
  assign byte_done = (bit_cnt_q == 4'd8);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    offset_d    = offset_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    pref_d      = {1'b0, pref_q[1]};

    // Prefetch lands once the memory has had a cycle to present the new offset.
    if (pref_q[0]) tx_d = mem_bus.mem_rdata;
    // The write strobe is issued against the old offset; advance right after it.
    if (mem_we_q) offset_d = offset_q + 8'd1;

    if (stop_det) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      if ((state_q == ADDR || state_q == OFFSET || state_q == WRITE) && scl_rise) begin
        shift_d   = {shift_q[6:0], sda_f};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      case (state_q)
        ADDR: if (scl_fall && byte_done) begin
          bit_cnt_d = '0;
          if (shift_q[7:1] == I2C_ADDR) begin
            state_d  = ADDR_ACK;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            rw_d     = shift_q[0];
            pref_d   = 2'b01;
          end else begin
            state_d = WAIT_STOP;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          bit_cnt_d = '0;
          if (rw_q) begin
            state_d  = READ;
            sda_oe_d = ~tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
          end else begin
            state_d  = OFFSET;
            sda_oe_d = 1'b0;
          end
        end
        OFFSET: if (scl_fall && byte_done) begin
          bit_cnt_d = '0;
          offset_d  = shift_q;
          state_d   = OFFSET_ACK;
          sda_oe_d  = 1'b1;
        end
        OFFSET_ACK, WRITE_ACK: if (scl_fall) begin
          bit_cnt_d = '0;
          state_d   = WRITE;
          sda_oe_d  = 1'b0;
        end
        WRITE: if (scl_fall && byte_done) begin
          bit_cnt_d   = '0;
          mem_we_d    = 1'b1;
          mem_wdata_d = shift_q;
          state_d     = WRITE_ACK;
          sda_oe_d    = 1'b1;
        end
        READ: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          else if (scl_fall) begin
            if (byte_done) begin
              bit_cnt_d = '0;
              state_d   = READ_ACK;
              sda_oe_d  = 1'b0;
            end else begin
              sda_oe_d = ~tx_q[7];
              tx_d     = {tx_q[6:0], 1'b0};
            end
          end
        end
        READ_ACK: begin
          // bit_cnt marks that the master's ACK clock has been sampled.
          if (scl_rise) begin
            bit_cnt_d = 4'd1;
            offset_d  = offset_q + 8'd1;
            if (sda_f) state_d = WAIT_STOP;
            else       pref_d  = 2'b10;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            state_d   = READ;
            sda_oe_d  = ~tx_q[7];
            tx_d      = {tx_q[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      prev_q      <= 2'b11;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      offset_q    <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      pref_q      <= '0;
    end else begin
      sync1_q     <= {sda_in, scl_in};
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      prev_q      <= filt_q;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      offset_q    <= offset_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      pref_q      <= pref_d;
    end
  end

  assign sda_oe            = sda_oe_q;
  assign busy              = busy_q;
  assign mem_bus.mem_addr  = offset_q;
  assign mem_bus.mem_we    = mem_we_q;
  assign mem_bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ddc_edid_slave.sv
// Directed bench for ddc_edid_slave: bit-banged I2C master, wired-AND SDA,
// registered EDID memory model holding mem[i] = i ^ 8'h5A.
module tb_ddc_edid_slave;
  localparam int Q = 10;

  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic glitch = 1'b0;
  logic scl_in, sda_in, sda_oe, busy;

  ddc_edid_slave_if bus();

  assign scl_in = m_scl & ~glitch;
  assign sda_in = m_sda & ~sda_oe;

  ddc_edid_slave #(.I2C_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk50   (clk50),
    .rst_n   (rst_n),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .mem_bus (bus)
  );

  always #10 clk50 = ~clk50;

  logic [7:0] mem [256];
  bit         mem_ready;
  logic [7:0] wr_a [$];
  logic [7:0] wr_d [$];

  always @(posedge clk50) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem_ready <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_a.push_back(bus.mem_addr);
      wr_d.push_back(bus.mem_wdata);
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // sda_oe activity and any change of sda_oe while SCL is high
  int   oe_cycles;
  int   hi_changes;
  logic oe_prev;
  always @(posedge clk50) begin
    if (sda_oe) oe_cycles <= oe_cycles + 1;
    if (rst_n && m_scl && (sda_oe !== oe_prev)) hi_changes <= hi_changes + 1;
    oe_prev <= sda_oe;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic clock_bit(input logic b, input bit gl, output logic rb);
    m_sda = b;
    cyc(Q);
    m_scl = 1'b1;
    cyc(Q);
    rb = sda_in;
    if (gl) begin
      glitch = 1'b1;
      cyc(1);
      glitch = 1'b0;
      cyc(Q - 1);
    end else begin
      cyc(Q);
    end
    m_scl = 1'b0;
    cyc(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; cyc(Q);
    m_scl = 1'b1; cyc(Q);
    m_sda = 1'b0; cyc(Q);
    m_scl = 1'b0; cyc(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; cyc(Q);
    m_scl = 1'b1; cyc(Q);
    m_sda = 1'b1; cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit gl, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], gl && (i == 3), dummy);
    clock_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, b);
      d[i] = b;
    end
    clock_bit(ack, 1'b0, b);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         base, oe_base, k;

    // Reset state
    cyc(5);
    rst_n = 1'b1;
    cyc(5);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_wdata", bus.mem_wdata, 8'h00);
    check("rst_offset", bus.mem_addr, 8'h00);

    // Random read: set offset 0, repeated start, 16 bytes (last NACKed)
    i2c_start();
    write_byte(8'hA0, 1'b0, ack); check("rr_ack_a0", ack, 1'b0);
    check("rr_busy", busy, 1'b1);
    write_byte(8'h00, 1'b0, ack); check("rr_ack_off", ack, 1'b0);
    i2c_start();
    write_byte(8'hA1, 1'b0, ack); check("rr_ack_a1", ack, 1'b0);
    for (int i = 0; i < 16; i++) begin
      read_byte((i == 15), d);
      check($sformatf("rr_data_%0d", i), d, 8'(i) ^ 8'h5A);
    end
    i2c_stop();
    cyc(Q);
    check("rr_busy_after", busy, 1'b0);
    check("rr_offset", bus.mem_addr, 8'h10);

    // Wrong address: never ACKed, SDA never driven
    oe_base = oe_cycles;
    i2c_start();
    write_byte(8'hA4, 1'b0, ack); check("wa_ack", ack, 1'b1);
    check("wa_busy", busy, 1'b0);
    write_byte(8'h00, 1'b0, ack); check("wa_ack2", ack, 1'b1);
    check("wa_oe_cycles", oe_cycles - oe_base, 0);
    i2c_stop();
    cyc(Q);
    check("wa_busy_after", busy, 1'b0);
    check("wa_offset", bus.mem_addr, 8'h10);

    // Write burst
    base = wr_a.size();
    i2c_start();
    write_byte(8'hA0, 1'b0, ack); check("wb_ack_a0", ack, 1'b0);
    write_byte(8'h10, 1'b0, ack); check("wb_ack_off", ack, 1'b0);
    write_byte(8'hAB, 1'b0, ack); check("wb_ack_d0", ack, 1'b0);
    write_byte(8'hCD, 1'b0, ack); check("wb_ack_d1", ack, 1'b0);
    i2c_stop();
    cyc(Q);
    check("wb_count", wr_a.size() - base, 2);
    if (wr_a.size() - base == 2) begin
      check("wb_addr0", wr_a[base],     8'h10);
      check("wb_data0", wr_d[base],     8'hAB);
      check("wb_addr1", wr_a[base + 1], 8'h11);
      check("wb_data1", wr_d[base + 1], 8'hCD);
    end
    check("wb_offset", bus.mem_addr, 8'h12);

    // Offset wrap and NACK
    i2c_start();
    write_byte(8'hA0, 1'b0, ack); check("wr_ack_a0", ack, 1'b0);
    write_byte(8'hFE, 1'b0, ack); check("wr_ack_off", ack, 1'b0);
    i2c_start();
    write_byte(8'hA1, 1'b0, ack); check("wr_ack_a1", ack, 1'b0);
    read_byte(1'b0, d); check("wr_data_fe", d, 8'hA4);
    read_byte(1'b0, d); check("wr_data_ff", d, 8'hA5);
    read_byte(1'b1, d); check("wr_data_00", d, 8'h5A);
    cyc(Q);
    check("wr_released", sda_oe, 1'b0);
    i2c_start();
    write_byte(8'hA1, 1'b0, ack); check("wr_ack_a1b", ack, 1'b0);
    read_byte(1'b1, d); check("wr_data_01", d, 8'h5B);
    i2c_stop();
    cyc(Q);
    check("wr_offset", bus.mem_addr, 8'h02);

    // Glitch on SCL during a data bit
    base = wr_a.size();
    i2c_start();
    write_byte(8'hA0, 1'b0, ack); check("gl_ack_a0", ack, 1'b0);
    write_byte(8'h20, 1'b0, ack); check("gl_ack_off", ack, 1'b0);
    write_byte(8'h3C, 1'b1, ack); check("gl_ack_d", ack, 1'b0);
    i2c_stop();
    cyc(Q);
    check("gl_count", wr_a.size() - base, 1);
    if (wr_a.size() - base == 1) begin
      check("gl_addr", wr_a[base], 8'h20);
      check("gl_data", wr_d[base], 8'h3C);
    end
    check("gl_offset", bus.mem_addr, 8'h21);

    // Reset mid-read while the slave drives a 0 (mem[0x21] = 0x7B)
    i2c_start();
    write_byte(8'hA1, 1'b0, ack); check("mr_ack_a1", ack, 1'b0);
    k = 0;
    while (!sda_oe && k < 20) begin
      cyc(1);
      k++;
    end
    check("mr_oe_driven", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_oe_released", sda_oe, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_we", bus.mem_we, 1'b0);
    cyc(2);
    m_sda = 1'b1; cyc(Q);
    m_scl = 1'b1; cyc(Q);
    rst_n = 1'b1;
    cyc(5);
    check("mr_offset", bus.mem_addr, 8'h00);
    check("mr_busy_idle", busy, 1'b0);
    i2c_start();
    write_byte(8'hA1, 1'b0, ack); check("mr_ack_again", ack, 1'b0);
    read_byte(1'b1, d); check("mr_data", d, 8'h5A);
    i2c_stop();
    cyc(Q);
    check("mr_offset_after", bus.mem_addr, 8'h01);
    check("mr_busy_after", busy, 1'b0);

    check("oe_stable_scl_high", hi_changes, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
